seq_alu: RTL and testbench

Parametrised, handshaked successor to the bit-sliced 32-bit ALU. It adds a registered output stage, valid/ready flow control, shift operations and a multi-cycle unsigned multiply. Compare modes are selected per operation, and signed compare is corrected for overflow. It sits between operand fetch and writeback in the datapath and accepts at most one operation in flight.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/seq_alu.sv | 169 ++++++++++++++++
 tb/tb_seq_alu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, compare modes, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SUB  = 4'b0110,
        OP_SET  = 4'b0111,
        OP_MULU = 4'b1000,
        OP_SLL  = 4'b1001,
        OP_SRL  = 4'b1010,
        OP_SRA  = 4'b1011,
        OP_NOR  = 4'b1100,
        OP_NAND = 4'b1101
    } op_t;

    typedef enum logic [2:0] {
        CMP_SLT = 3'b000,
        CMP_SGT = 3'b001,
        CMP_SLE = 3'b010,
        CMP_SGE = 3'b011,
        CMP_NE  = 3'b100,
        CMP_EQ  = 3'b110
    } cmp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle.
// product_o carries the final partial product in the cycle done_o is high.
module alu_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int SHW = $clog2(WIDTH);

    logic               active_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH:0]     partial;
    logic [2*WIDTH-1:0] acc_d;

    // Low half of acc starts as the multiplier and shifts out one bit per step
    always_comb begin
        partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        if (acc_q[0]) begin
            partial = partial + {1'b0, mcand_q};
        end
        acc_d = {partial, acc_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else if (start_i) begin
            active_q <= 1'b1;
            cnt_q    <= SHW'(WIDTH - 1);
            mcand_q  <= a_i;
            acc_q    <= {{WIDTH{1'b0}}, b_i};
        end else if (active_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end
        end
    end

    assign done_o    = active_q && (cnt_q == '0);
    assign product_o = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU with registered results and a multi-cycle unsigned multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [2:0]       cmp,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    op_t                opc;
    cmp_t               cm;
    logic               inv_b;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum;
    logic               add_ovf;
    logic               less;
    logic               eq;
    logic               set_bit;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (src1),
        .b_i       (src2),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    always_comb begin
        opc     = op_t'(op);
        cm      = cmp_t'(cmp);
        inv_b   = (opc == OP_SUB) || (opc == OP_SET);
        b_eff   = inv_b ? ~src2 : src2;
        sum     = {1'b0, src1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, inv_b};
        add_ovf = (src1[WIDTH-1] == b_eff[WIDTH-1])
               && (sum[WIDTH-1] != src1[WIDTH-1]);
        // Sign of the difference, corrected when the subtraction overflows
        less    = sum[WIDTH-1] ^ add_ovf;
        eq      = (src1 == src2);
        shamt   = src2[SHW-1:0];

        set_bit = 1'b0;
        unique case (cm)
            CMP_SLT: set_bit = less;
            CMP_SGT: set_bit = !less && !eq;
            CMP_SLE: set_bit = less || eq;
            CMP_SGE: set_bit = !less;
            CMP_NE:  set_bit = !eq;
            CMP_EQ:  set_bit = eq;
            default: set_bit = 1'b0;
        endcase

        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (opc)
            OP_AND:  alu_res = src1 & src2;
            OP_OR:   alu_res = src1 | src2;
            OP_NOR:  alu_res = ~(src1 | src2);
            OP_NAND: alu_res = ~(src1 & src2);
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = add_ovf;
            end
            OP_SET:  alu_res = {{(WIDTH-1){1'b0}}, set_bit};
            OP_SLL:  alu_res = src1 << shamt;
            OP_SRL:  alu_res = src1 >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(src1) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        mul_start = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (in_ready) begin
                    if (!in_valid) begin
                        state_d = IDLE;
                    end else if (opc == OP_MULU) begin
                        mul_start = 1'b1;
                        state_d   = MUL;
                    end else begin
                        result_d = alu_res;
                        cout_d   = alu_cout;
                        ovf_d    = alu_ovf;
                        state_d  = DONE;
                    end
                end
            end
            MUL: begin
                if (mul_done) begin
                    result_d = mul_prod[WIDTH-1:0];
                    cout_d   = |mul_prod[2*WIDTH-1:WIDTH];
                    ovf_d    = 1'b0;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (state_d == state_q) && (state_q != MUL) && !in_ready
               ? zero_q : (result_d == '0);
        if (state_d == IDLE || state_d == MUL) begin
            zero_d = zero_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == MUL);
    assign result    = result_q;
    assign zero      = zero_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH=32 with hand-computed expectations.
module tb_seq_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [2:0]  cmp;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .cmp       (cmp),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [2:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        op       = o;
        cmp      = c;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        src1     = 32'hDEAD_BEEF;
        src2     = 32'hCAFE_F00D;
    endtask

    task automatic check_out(input string tag, input logic [31:0] r,
                             input logic z, input logic c, input logic v);
        check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, ".result"}, result, r);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
        check({tag, ".cout"}, {31'b0, cout}, {31'b0, c});
        check({tag, ".ovf"}, {31'b0, overflow}, {31'b0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'b0;
        cmp       = 3'b0;
        src1      = '0;
        src2      = '0;
        tick();
        tick();
        check("rst.valid", {31'b0, out_valid}, 32'd0);
        check("rst.result", result, 32'd0);
        check("rst.zero", {31'b0, zero}, 32'd0);
        check("rst.busy", {31'b0, busy}, 32'd0);
        check("rst.in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // ADD overflow, out_valid right after acceptance
        issue(4'b0010, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        check_out("add", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();
        check("add.drain", {31'b0, out_valid}, 32'd0);

        issue(4'b0110, 3'b000, 32'd5, 32'd5);
        check_out("sub", 32'd0, 1'b1, 1'b1, 1'b0);
        tick();

        issue(4'b0111, 3'b000, 32'h8000_0000, 32'h0000_0001);
        check_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
        tick();

        issue(4'b0111, 3'b000, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        check_out("slt_ovf", 32'd0, 1'b1, 1'b0, 1'b0);
        tick();

        issue(4'b0111, 3'b110, 32'h0000_1234, 32'h0000_1234);
        check_out("seq", 32'd1, 1'b0, 1'b0, 1'b0);
        tick();

        issue(4'b0111, 3'b001, 32'd3, 32'd2);
        check_out("sgt", 32'd1, 1'b0, 1'b0, 1'b0);
        tick();

        issue(4'b1001, 3'b000, 32'h0000_0001, 32'h0000_003F);
        check_out("sll", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        tick();

        issue(4'b1101, 3'b000, 32'hF0F0_0000, 32'hFF00_FFFF);
        check_out("nand", 32'h0FFF_FFFF, 1'b0, 1'b0, 1'b0);
        tick();

        issue(4'b0011, 3'b000, 32'hFFFF_FFFF, 32'h1);
        check("unk.valid", {31'b0, out_valid}, 32'd1);
        check("unk.result", result, 32'd0);
        check("unk.cout", {31'b0, cout}, 32'd0);
        tick();

        // MULU: 32 cycles busy, then the product
        issue(4'b1000, 3'b000, 32'h0001_0000, 32'h0001_0000);
        check("mul.busy0", {31'b0, busy}, 32'd1);
        check("mul.rdy0", {31'b0, in_ready}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            tick();
            check("mul.wait_valid", {31'b0, out_valid}, 32'd0);
            check("mul.wait_busy", {31'b0, busy}, 32'd1);
            check("mul.wait_rdy", {31'b0, in_ready}, 32'd0);
        end
        tick();
        check_out("mul", 32'd0, 1'b1, 1'b1, 1'b0);
        check("mul.busy_end", {31'b0, busy}, 32'd0);
        tick();

        issue(4'b1000, 3'b000, 32'h1234_5678, 32'd9);
        for (int i = 1; i < 32; i++) begin
            tick();
        end
        tick();
        check_out("mul2", 32'hA3D7_0A38, 1'b0, 1'b0, 1'b0);
        tick();

        // SRA with consumer stalled, then back-to-back ADD
        out_ready = 1'b0;
        issue(4'b1011, 3'b000, 32'h8000_0000, 32'h0000_0024);
        check_out("sra", 32'hF800_0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.result", result, 32'hF800_0000);
            check("stall.valid", {31'b0, out_valid}, 32'd1);
            check("stall.rdy", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        op        = 4'b0010;
        src1      = 32'd3;
        src2      = 32'd4;
        in_valid  = 1'b1;
        #1;
        check("b2b.rdy", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check_out("b2b", 32'd7, 1'b0, 1'b0, 1'b0);

        // Reset on cycle 10 of a MULU aborts it
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b1;
        tick();
        issue(4'b1000, 3'b000, 32'h0000_FFFF, 32'h0001_0001);
        for (int i = 1; i < 10; i++) begin
            tick();
        end
        check("abort.busy_pre", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort.valid", {31'b0, out_valid}, 32'd0);
        check("abort.busy", {31'b0, busy}, 32'd0);
        check("abort.result", result, 32'd0);
        check("abort.flags", {29'b0, zero, cout, overflow}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("abort.rdy", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort.no_out", {31'b0, out_valid}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
